// File: rtl/ram_sp_arbiter_if.sv
// ram_sp_arbiter_if: requester command/response bundle plus the RAM pins owned by ram_sp_arbiter.
interface ram_sp_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic                          ram_cs;
  logic                          ram_oe;
  logic                          ram_we;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic                          ram_wdata_en;
  logic [DATA_WIDTH-1:0]         ram_rdata;
  logic                          busy;
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_cs, ram_oe, ram_we,
           ram_wdata, ram_wdata_en, busy
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_cs, ram_oe, ram_we,
           ram_wdata, ram_wdata_en, busy
  );
endinterface

// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: round-robin sharing of one async-read/sync-write single-port RAM,
// one command per IDLE/RESP -> ACCESS -> RESP sequence.
module ram_sp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input logic             clk,
  input logic             rst_n,
  ram_sp_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d, cmd_id_q, cmd_id_d, g;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d, rdata_q, rdata_d;
  logic                    cmd_we_q, cmd_we_d;
  logic                    cs_q, cs_d, oe_q, oe_d, we_q, we_d;
  logic [NUM_REQ-1:0]      rsp_q, rsp_d;
  logic                    found, grant;
  logic [PW:0]             sum;
  logic [PW-1:0]           idx;
  logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cmd_id_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_we_q    <= 1'b0;
      rdata_q     <= '0;
      cs_q        <= 1'b0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_id_q    <= cmd_id_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_we_q    <= cmd_we_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      rsp_q       <= rsp_d;
    end
  end
  // first valid requester at or after ptr, wrapping at NUM_REQ
  always_comb begin
    g     = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      idx = sum >= (PW+1)'(NUM_REQ) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
      if (!found && bus.req_valid[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
    grant = found && state_q != ACCESS;
  end
  always_comb begin
    state_d     = state_q == ACCESS ? RESP : (grant ? ACCESS : IDLE);
    ptr_d       = grant ? (g == PW'(NUM_REQ - 1) ? '0 : g + 1'b1) : ptr_q;
    cmd_id_d    = grant ? g : cmd_id_q;
    cmd_addr_d  = grant ? addr_a[g] : cmd_addr_q;
    cmd_wdata_d = grant ? wdata_a[g] : cmd_wdata_q;
    cmd_we_d    = grant ? bus.req_we[g] : cmd_we_q;
    rdata_d     = state_q == ACCESS && !cmd_we_q ? bus.ram_rdata : rdata_q;
  end
  // RAM strobes are computed one cycle ahead so they leave flops cleanly
  always_comb begin
    cs_d          = grant;
    oe_d          = grant && !bus.req_we[g];
    we_d          = grant && bus.req_we[g];
    rsp_d         = state_q == ACCESS ? NUM_REQ'(1) << cmd_id_q : '0;
    bus.req_ready = grant ? NUM_REQ'(1) << g : '0;
  end
  assign bus.rsp_valid    = rsp_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.ram_addr     = cmd_addr_q;
  assign bus.ram_wdata    = cmd_wdata_q;
  assign bus.ram_cs       = cs_q;
  assign bus.ram_oe       = oe_q;
  assign bus.ram_we       = we_q;
  assign bus.ram_wdata_en = we_q;
  assign bus.busy         = state_q == ACCESS;
endmodule
